multi_stream_grabber: RTL

MULTI_STREAM_GRABBER -- requirements
Module: multi_stream_grabber

---
 rtl/multi_stream_grabber.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_stream_grabber.sv
// Multi-channel snapshot grabber. Each enabled channel records into its own
// circular buffer while armed, keeps POST_SAMPLES samples after the trigger,
// then all frozen buffers are streamed out as bytes over a valid/ready port.
module multi_stream_grabber #(
  parameter int NUM_CH       = 4,
  parameter int DAT_WIDTH    = 72,
  parameter int ADDR_BITS    = 4,
  parameter int POST_SAMPLES = 8
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic [DAT_WIDTH*NUM_CH-1:0] data_in,
  input  logic [NUM_CH-1:0]           data_in_valid,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic                        start_harvest,
  input  logic                        trigger,
  input  logic                        abort,
  output logic [7:0]                  dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        reporting,
  output logic                        armed
);

  localparam int Depth    = 1 << ADDR_BITS;
  localparam int NumBytes = DAT_WIDTH / 8;
  localparam int ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FillW    = ADDR_BITS + 1;
  localparam int ByteW    = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArmed  = 2'd1;
  localparam logic [1:0] StPost   = 2'd2;
  localparam logic [1:0] StReport = 2'd3;

  localparam logic [1:0] PhHeader = 2'd0;
  localparam logic [1:0] PhCount  = 2'd1;
  localparam logic [1:0] PhData   = 2'd2;

  logic [1:0]           state_q;
  logic [NUM_CH-1:0]    mask_q;
  logic [ADDR_BITS-1:0] wr_ptr_q [NUM_CH];
  logic [FillW-1:0]     fill_q   [NUM_CH];
  logic [FillW-1:0]     post_q   [NUM_CH];
  logic [DAT_WIDTH-1:0] mem      [NUM_CH][Depth];

  logic [NUM_CH-1:0]    wr_en;
  logic [NUM_CH-1:0]    frozen;
  logic                 all_frozen;

  // Report sequencer position: channel, byte class, sample and byte within sample.
  // cur_ch_q == NUM_CH means nothing left to emit.
  logic [ChW:0]         cur_ch_q;
  logic [1:0]           phase_q;
  logic [FillW-1:0]     smp_q;
  logic [ByteW-1:0]     byte_q;

  logic [ChW-1:0]       ch;
  logic                 have_byte;
  logic [FillW-1:0]     cnt;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DAT_WIDTH-1:0] sample;
  logic [7:0]           next_byte;
  logic [ChW:0]         nxt_ch;
  logic [1:0]           nxt_phase;
  logic [FillW-1:0]     nxt_smp;
  logic [ByteW-1:0]     nxt_byte;

  // Lowest enabled channel with index >= from, or NUM_CH if none.
  function automatic logic [ChW:0] next_enabled(input logic [NUM_CH-1:0] m, input int from);
    logic [ChW:0] r;
    r = (ChW+1)'(NUM_CH);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = (ChW+1)'(i);
    end
    return r;
  endfunction

  // Per-channel write enables and freeze detection.
  always_comb begin
    all_frozen = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      frozen[i] = (post_q[i] == FillW'(POST_SAMPLES));
      wr_en[i]  = mask_q[i] && data_in_valid[i] &&
                  ((state_q == StArmed) || ((state_q == StPost) && !frozen[i]));
      if (mask_q[i] && !frozen[i]) all_frozen = 1'b0;
    end
  end

  // Sample memories; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en[i]) mem[i][wr_ptr_q[i]] <= data_in[DAT_WIDTH*i +: DAT_WIDTH];
    end
  end

  // Channel bookkeeping: mask latch, write pointers, fill and post-trigger counts.
  always_ff @(posedge clk) begin
    if (srst) begin
      mask_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        fill_q[i]   <= '0;
        post_q[i]   <= '0;
      end
    end else if ((state_q == StIdle) && start_harvest && !abort) begin
      mask_q <= ch_enable;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        fill_q[i]   <= '0;
        post_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
          if (fill_q[i] != FillW'(Depth)) fill_q[i] <= fill_q[i] + 1'b1;
          // A sample taken in the trigger cycle already counts as post sample 1.
          if ((state_q == StPost) || trigger) post_q[i] <= post_q[i] + 1'b1;
        end
      end
    end
  end

  // Next report byte and sequencer advance; memory read is asynchronous so no bubbles.
  always_comb begin
    ch        = cur_ch_q[ChW-1:0];
    have_byte = (cur_ch_q < (ChW+1)'(NUM_CH));
    cnt       = fill_q[ch];
    rd_addr   = ((cnt == FillW'(Depth)) ? wr_ptr_q[ch] : '0) + smp_q[ADDR_BITS-1:0];
    sample    = mem[ch][rd_addr];
    next_byte = '0;
    nxt_ch    = cur_ch_q;
    nxt_phase = phase_q;
    nxt_smp   = smp_q;
    nxt_byte  = byte_q;
    case (phase_q)
      PhHeader: begin
        next_byte = {4'(cur_ch_q), 4'b0};
        nxt_phase = PhCount;
      end
      PhCount: begin
        next_byte = 8'(cnt);
        if (cnt == '0) begin
          nxt_ch    = next_enabled(mask_q, int'(cur_ch_q) + 1);
          nxt_phase = PhHeader;
        end else begin
          nxt_phase = PhData;
          nxt_smp   = '0;
          nxt_byte  = '0;
        end
      end
      default: begin
        next_byte = 8'(sample >> (8 * (NumBytes - 1 - int'(byte_q))));
        if (byte_q == ByteW'(NumBytes - 1)) begin
          nxt_byte = '0;
          if (smp_q == cnt - 1'b1) begin
            nxt_ch    = next_enabled(mask_q, int'(cur_ch_q) + 1);
            nxt_phase = PhHeader;
            nxt_smp   = '0;
          end else begin
            nxt_smp = smp_q + 1'b1;
          end
        end else begin
          nxt_byte = byte_q + 1'b1;
        end
      end
    endcase
  end

  // Control FSM and registered byte output.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= StIdle;
      dout       <= '0;
      dout_valid <= 1'b0;
      cur_ch_q   <= '0;
      phase_q    <= PhHeader;
      smp_q      <= '0;
      byte_q     <= '0;
    end else if (abort) begin
      state_q    <= StIdle;
      dout_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_harvest) begin
            phase_q <= PhHeader;
            smp_q   <= '0;
            byte_q  <= '0;
            if (ch_enable == '0) begin
              state_q  <= StReport;
              cur_ch_q <= (ChW+1)'(NUM_CH);
            end else begin
              state_q <= StArmed;
            end
          end
        end
        StArmed: begin
          if (trigger) state_q <= StPost;
        end
        StPost: begin
          if (all_frozen) begin
            state_q  <= StReport;
            cur_ch_q <= next_enabled(mask_q, 0);
            phase_q  <= PhHeader;
            smp_q    <= '0;
            byte_q   <= '0;
          end
        end
        default: begin
          if (!dout_valid || dout_ready) begin
            if (have_byte) begin
              dout       <= next_byte;
              dout_valid <= 1'b1;
              cur_ch_q   <= nxt_ch;
              phase_q    <= nxt_phase;
              smp_q      <= nxt_smp;
              byte_q     <= nxt_byte;
            end else begin
              dout_valid <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end
      endcase
    end
  end

  assign reporting = (state_q == StReport);
  assign armed     = (state_q == StArmed) || (state_q == StPost);

endmodule
